// File: rtl/spi_master_byte.sv
// SPI mode-0 master byte engine: streams valid/ready bytes onto MOSI, returns MISO bytes as
// one-cycle pulses, and keeps NSS low across a burst until the byte tagged TX_LAST completes.
module spi_master_byte #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  input  logic       TX_LAST,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY,
  output logic       SPI_SCLK,
  output logic       SPI_NSS,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned HW = 4;
  localparam logic [CW-1:0] HALF_M1   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LEAD2_M1  = CW'(CLK_DIV);
  localparam logic [HW-1:0] HALF_FALL8 = HW'(14);
  localparam logic [HW-1:0] HALF_END   = HW'(15);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_LEAD2, S_SHIFT, S_WAIT, S_TRAIL, S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] half_q, half_d;
  logic          last_q, last_d;
  logic [DW-1:0] sr_q, sr_d;
  logic          sclk_q, sclk_d;
  logic          nss_q, nss_d;
  logic          mosi_q, mosi_d;
  logic          tx_ready_q, tx_ready_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;

  logic accept_c;
  logic rise_c;
  logic fall_c;
  logic done_c;

  assign accept_c = TX_VALID & tx_ready_q;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      last_q     <= 1'b0;
      sr_q       <= '0;
      sclk_q     <= 1'b0;
      nss_q      <= 1'b1;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      last_q     <= last_d;
      sr_q       <= sr_d;
      sclk_q     <= sclk_d;
      nss_q      <= nss_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next state, phase counter and SCLK edge events
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    last_d  = last_q;
    rise_c  = 1'b0;
    fall_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_LEAD;
          cnt_d   = HALF_M1;
          last_d  = TX_LAST;
        end
      end
      S_LEAD, S_LEAD2: begin
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          cnt_d   = HALF_M1;
          half_d  = '0;
          rise_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (half_q == HALF_END) begin
          // last SCLK low half-period done; offer the next byte of the burst
          state_d = S_WAIT;
        end else begin
          cnt_d  = HALF_M1;
          half_d = half_q + HW'(1);
          rise_c = half_q[0];
          fall_c = ~half_q[0];
          if (half_q == HALF_FALL8) begin
            done_c = 1'b1;
            if (last_q) begin
              state_d = S_TRAIL;
            end
          end
        end
      end
      S_WAIT: begin
        if (accept_c) begin
          state_d = S_LEAD2;
          cnt_d   = LEAD2_M1;
          last_d  = TX_LAST;
        end
      end
      S_TRAIL: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = HALF_M1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs follow the next state so every port comes straight from a flop
  always_comb begin
    sclk_d     = (state_d == S_SHIFT) && !half_d[0];
    nss_d      = (state_d == S_IDLE) || (state_d == S_GAP);
    tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    busy_d     = (state_d != S_IDLE);
    rx_valid_d = done_c;
    rx_data_d  = done_c ? sr_q : rx_data_q;
    sr_d       = sr_q;
    mosi_d     = mosi_q;
    if (accept_c) begin
      sr_d   = TX_DATA;
      mosi_d = TX_DATA[DW-1];
    end else if (rise_c) begin
      sr_d = {sr_q[DW-2:0], SPI_MISO};
    end
    if (fall_c && !done_c) begin
      mosi_d = sr_q[DW-1];
    end
  end

  assign TX_READY = tx_ready_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign BUSY     = busy_q;
  assign SPI_SCLK = sclk_q;
  assign SPI_NSS  = nss_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte: two instances (CLK_DIV=2 and 4), loopback or slave-model
// MISO, RX bytes checked against a scoreboard queue filled when each byte is sent.
module tb_spi_master_byte;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data [2];
  logic [7:0] rx_data [2];
  logic [1:0] tx_valid, tx_last, tx_ready, rx_valid, busy, sclk, nss, mosi, miso;
  logic [1:0] loop_en, sbit;

  int tests;
  int fails;
  int cyc_abs;
  logic [7:0] exp_q [$];

  int         r_rises, r_rx_cnt, r_rx_cyc, r_rx_abs, r_nss_rise, r_ready_cyc, r_viol;
  logic       r_nss1;
  logic [7:0] r_pat;

  assign miso = (loop_en & mosi) | (~loop_en & sbit);

  spi_master_byte #(.CLK_DIV(2)) u_div2 (
    .CLK(clk), .RESET_N(rst_n), .TX_DATA(tx_data[0]), .TX_VALID(tx_valid[0]),
    .TX_LAST(tx_last[0]), .TX_READY(tx_ready[0]), .RX_DATA(rx_data[0]),
    .RX_VALID(rx_valid[0]), .BUSY(busy[0]), .SPI_SCLK(sclk[0]), .SPI_NSS(nss[0]),
    .SPI_MOSI(mosi[0]), .SPI_MISO(miso[0])
  );

  spi_master_byte #(.CLK_DIV(4)) u_div4 (
    .CLK(clk), .RESET_N(rst_n), .TX_DATA(tx_data[1]), .TX_VALID(tx_valid[1]),
    .TX_LAST(tx_last[1]), .TX_READY(tx_ready[1]), .RX_DATA(rx_data[1]),
    .RX_VALID(rx_valid[1]), .BUSY(busy[1]), .SPI_SCLK(sclk[1]), .SPI_NSS(nss[1]),
    .SPI_MOSI(mosi[1]), .SPI_MISO(miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int div(input int u);
    return (u == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_abs++;
  endtask

  task automatic chk_reset(input int u);
    chk("rst_sclk", 32'(sclk[u]), 0);
    chk("rst_nss", 32'(nss[u]), 1);
    chk("rst_mosi", 32'(mosi[u]), 0);
    chk("rst_tx_ready", 32'(tx_ready[u]), 0);
    chk("rst_rx_valid", 32'(rx_valid[u]), 0);
    chk("rst_rx_data", 32'(rx_data[u]), 0);
    chk("rst_busy", 32'(busy[u]), 0);
  endtask

  // Send one byte and watch the link until TX_READY comes back
  task automatic xfer(input int u, input logic [7:0] d, input logic last, input logic lp,
                      input logic [7:0] sb, input logic hold, input logic [7:0] nxt);
    int n;
    int cyc;
    int idx;
    logic ps;
    logic pm;
    logic [7:0] e;
    loop_en[u] = lp;
    exp_q.push_back(lp ? d : sb);
    tx_data[u]  = d;
    tx_last[u]  = last;
    tx_valid[u] = 1'b1;
    idx = 7;
    sbit[u] = sb[7];
    n = 0;
    while (tx_ready[u] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("ready_before_accept", 32'(tx_ready[u]), 1);
    ps = sclk[u];
    pm = mosi[u];
    step();
    if (hold) tx_data[u] = nxt;
    else tx_valid[u] = 1'b0;
    r_rises = 0; r_rx_cnt = 0; r_rx_cyc = 0; r_rx_abs = 0;
    r_nss_rise = 0; r_ready_cyc = 0; r_viol = 0; r_pat = '0;
    r_nss1 = nss[u];
    cyc = 1;
    while (cyc <= 18 * div(u) + 10) begin
      if (sclk[u] && !ps) begin
        r_rises++;
        r_pat = {r_pat[6:0], pm};
      end
      if (!sclk[u] && ps && idx > 0) begin
        idx--;
        sbit[u] = sb[idx];
      end
      if (mosi[u] !== pm && sclk[u]) r_viol++;
      if (nss[u] && r_nss_rise == 0) r_nss_rise = cyc;
      if (rx_valid[u]) begin
        r_rx_cnt++;
        r_rx_cyc = cyc;
        r_rx_abs = cyc_abs;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(rx_data[u]), 32'(e));
        end
      end
      if (tx_ready[u]) begin
        r_ready_cyc = cyc;
        break;
      end
      ps = sclk[u];
      pm = mosi[u];
      step();
      cyc++;
    end
  endtask

  task automatic chk_xfer(input int u, input int off, input logic last, input logic [7:0] pat);
    int dv;
    dv = div(u);
    chk("sclk_rises", r_rises, 8);
    chk("rx_pulses", r_rx_cnt, 1);
    chk("rx_cycle", r_rx_cyc, off + 16 * dv);
    chk("nss_low_cycle1", 32'(r_nss1), 0);
    chk("nss_rise_cycle", r_nss_rise, last ? off + 17 * dv : 0);
    chk("ready_cycle", r_ready_cyc, last ? off + 18 * dv : off + 17 * dv);
    chk("mosi_pattern", 32'(r_pat), 32'(pat));
    chk("mode0_mosi_stable", r_viol, 0);
  endtask

  initial begin
    int rx_abs_first;
    int bad;
    int rises;
    int n;
    logic ps;
    tests = 0; fails = 0; cyc_abs = 0;
    rst_n = 1'b0;
    tx_valid = '0; tx_last = '0; loop_en = '0; sbit = '0;
    tx_data[0] = '0; tx_data[1] = '0;
    repeat (3) step();
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    step();
    chk("ready_after_reset_d2", 32'(tx_ready[0]), 1);
    chk("ready_after_reset_d4", 32'(tx_ready[1]), 1);

    // single byte loopback, CLK_DIV=2
    xfer(0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_xfer(0, 1, 1'b1, 8'hA5);
    chk("rx_hold_a5", 32'(rx_data[0]), 32'hA5);

    // burst with slave model, TX_VALID held between bytes, CLK_DIV=4
    xfer(1, 8'h3C, 1'b0, 1'b0, 8'h81, 1'b1, 8'h3C);
    chk_xfer(1, 1, 1'b0, 8'h3C);
    rx_abs_first = r_rx_abs;
    xfer(1, 8'hC3, 1'b1, 1'b0, 8'h7E, 1'b0, 8'h00);
    chk_xfer(1, 2, 1'b1, 8'hC3);
    chk("burst_rx_spacing", r_rx_abs - rx_abs_first, 17 * 4 + 2);

    // MOSI pattern for 0x80 then 0x01 in one burst
    xfer(0, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_xfer(0, 1, 1'b0, 8'h80);
    xfer(0, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_xfer(0, 2, 1'b1, 8'h01);

    // WAIT stall: no TX_VALID for 200 cycles mid-burst
    xfer(1, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_xfer(1, 1, 1'b0, 8'h5A);
    bad = 0;
    repeat (200) begin
      step();
      if (nss[1] !== 1'b0 || sclk[1] !== 1'b0 || tx_ready[1] !== 1'b1 ||
          busy[1] !== 1'b1 || rx_valid[1] !== 1'b0) bad++;
    end
    chk("wait_stall_hold", bad, 0);
    chk("rx_hold_5a", 32'(rx_data[1]), 32'h5A);
    xfer(1, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_xfer(1, 2, 1'b1, 8'h96);

    // reset after the 3rd SCLK rising edge aborts the byte
    loop_en[1] = 1'b1;
    tx_data[1] = 8'hF0; tx_last[1] = 1'b1; tx_valid[1] = 1'b1;
    n = 0;
    while (tx_ready[1] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    step();
    tx_valid[1] = 1'b0;
    rises = 0; bad = 0; n = 0;
    ps = sclk[1];
    while (rises < 3 && n < 200) begin
      step();
      n++;
      if (sclk[1] && !ps) rises++;
      if (rx_valid[1]) bad++;
      ps = sclk[1];
    end
    chk("abort_rises_seen", rises, 3);
    rst_n = 1'b0;
    step();
    chk("abort_nss", 32'(nss[1]), 1);
    chk("abort_sclk", 32'(sclk[1]), 0);
    chk("abort_rx_valid", 32'(rx_valid[1]), 0);
    chk("abort_busy", 32'(busy[1]), 0);
    chk("abort_rx_data", 32'(rx_data[1]), 0);
    rst_n = 1'b1;
    step();
    chk("abort_ready_after_release", 32'(tx_ready[1]), 1);
    repeat (40) begin
      step();
      if (rx_valid[1] || busy[1]) bad++;
    end
    chk("abort_no_rx", bad, 0);
    xfer(1, 8'h55, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_xfer(1, 1, 1'b1, 8'h55);

    // back-pressure: TX_VALID held with new data while busy
    xfer(0, 8'h11, 1'b1, 1'b1, 8'h00, 1'b1, 8'hEE);
    chk_xfer(0, 1, 1'b1, 8'h11);
    xfer(0, 8'hEE, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00);
    chk_xfer(0, 1, 1'b1, 8'hEE);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
